uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
Frame controller for the UART receiver, sitting upstream of the start, parity and stop checkers and of the deserializer.
- Tracks oversampled edge and bit position of each incoming frame.
- Pulses the checker and deserializer enables at the decided sampling edge.
- Collects the registered error flags and issues a single-cycle data_valid for clean frames.
- Drives the en input of the stop checker; consumes its registered stp_err one cycle later.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (LSB first)
PRESCALE_W, 6, width of prescale and edge_cnt

Ports:
clk  input  1  system clock (oversampling clock)
rst  input  1  asynchronous, active-low reset
rx_in  input  1  serial line, idle high, synchronized upstream
prescale  input  PRESCALE_W  oversampling ratio; legal 8, 16, 32
par_en  input  1  1 = frame carries a parity bit
strt_glitch  input  1  registered start-checker result, 1 = start bit not low
par_err  input  1  registered parity-checker result
stp_err  input  1  registered stop-checker result
dat_samp_en  output  1  enables the majority sampler while a frame is active
edge_cnt  output  PRESCALE_W  current oversample index within the bit
bit_cnt  output  4  current bit index within the frame
strt_chk_en  output  1  one-cycle enable to start checker
deser_en  output  1  one-cycle shift enable to deserializer
par_chk_en  output  1  one-cycle enable to parity checker
stp_chk_en  output  1  one-cycle enable to stop checker
data_valid  output  1  one-cycle pulse: deserializer holds a clean byte
frame_err  output  1  one-cycle pulse: frame ended with parity or stop error

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; latched cfg cleared.
- Reset mid-frame aborts the frame; no data_valid or frame_err follows.
- Frame start: in IDLE, rx_in == 0 on a clk edge -> START next cycle with edge_cnt = 0, bit_cnt = 0.
  - The same edge latches par_en and prescale.
  - Latched prescale values below 8 clamp to 8.
  - Changes to par_en or prescale mid-frame are ignored.
- Constants: CHK_EDGE = P/2 + 2; LAST = P - 1, where P is the latched prescale. CHK_EDGE is the cycle the sampler output is valid.
- Counters (active in every non-IDLE state):
  - edge_cnt increments each cycle.
  - At LAST, edge_cnt wraps to 0 and bit_cnt increments.
  - In IDLE both are held at 0.
- States: IDLE, START, DATA, PARITY, STOP. dat_samp_en = 1 in every non-IDLE state.
- START:
  - strt_chk_en pulses at CHK_EDGE.
  - At LAST: strt_glitch == 1 -> IDLE with no pulses; otherwise -> DATA.
- DATA:
  - deser_en pulses at CHK_EDGE of each of DATA_WIDTH bits.
  - At LAST of bit DATA_WIDTH -> PARITY if par_en latched, else STOP.
- PARITY:
  - par_chk_en pulses at CHK_EDGE.
  - At LAST, par_err is captured into a sticky frame flag; -> STOP.
- STOP:
  - stp_chk_en pulses at CHK_EDGE.
  - At LAST, evaluate err = stp_err | sticky par flag.
  - err == 0 -> data_valid = 1 for the next cycle only; err == 1 -> frame_err = 1 for the next cycle only.
  - Next state is START if rx_in == 0 at that edge (back-to-back frame, counters reset to 0), else IDLE.
  - The sticky flag clears on leaving STOP.
- Enables and error pulses never overlap within a cycle; each appears at most once per bit.
- bit_cnt never exceeds DATA_WIDTH + 2.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_WIDTH and PRESCALE_W defaults;
  - the CHK_EDGE offset (2).
- Sub-module edge_bit_cnt holds edge_cnt/bit_cnt with wrap against the latched prescale; inputs are count enable and clear.

Test Plan:
- prescale = 8, par_en = 0, frame 0xA5 with stop = 1; count cycles from the first START cycle as 0:
  - deser_en high at cycles 14, 22, …, 70;
  - stp_chk_en high at cycle 78;
  - data_valid high only at cycle 80.
- prescale = 16, par_en = 1, checker model returns par_err = 1 on a good stop bit -> no data_valid; frame_err pulses once at cycle 176.
- prescale = 8, stp_err = 1 from the checker model -> frame_err high at cycle 80; data_valid stays 0.
- rx_in low for 3 cycles with strt_glitch = 1 at LAST of START -> return to IDLE at cycle 8; no deser_en or any other enable after strt_chk_en.
- Back-to-back frames 0x3C and 0xC3 with stop bit held for exactly one bit time, prescale = 8, no parity -> two data_valid pulses 80 cycles apart; the second frame's START begins the cycle after the first frame's LAST.
- rst driven low at cycle 40 of a frame -> all outputs 0 immediately; after release with rx_in high, no pulses appear.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive frame controller.
package uart_rx_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 6;
  localparam int CHK_OFS        = 2;  // sampler output settles this many edges past mid-bit
  localparam int MIN_PRESCALE   = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_fsm_edge_bit_cnt.sv
// Oversample edge counter and bit position counter; edge wraps at the latched LAST.
module edge_bit_cnt #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] last,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  at_last
);
  assign at_last = (edge_cnt == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (at_last) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: tracks bit/edge position, pulses checker and
// deserializer enables at the sampling edge, and reports clean or errored frames.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  frame_err
);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(MIN_PRESCALE);

  rx_state_e             state, state_nx;
  logic [PRESCALE_W-1:0] p_lat, p_in, last_e, chk_e;
  logic                  par_lat, par_flag;
  logic                  cnt_en, cnt_clr, at_last, at_chk;
  logic                  load_cfg, cap_par, eval_stop, frm_bad;

  assign p_in    = (prescale < P_MIN) ? P_MIN : prescale;
  assign last_e  = p_lat - 1'b1;
  assign chk_e   = (p_lat >> 1) + PRESCALE_W'(CHK_OFS);
  assign at_chk  = (edge_cnt == chk_e);
  assign frm_bad = stp_err | par_flag;

  edge_bit_cnt #(.PRESCALE_W(PRESCALE_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .last     (last_e),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .at_last  (at_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      p_lat      <= '0;
      par_lat    <= 1'b0;
      par_flag   <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      data_valid <= eval_stop & ~frm_bad;
      frame_err  <= eval_stop & frm_bad;
      if (load_cfg) begin
        p_lat   <= p_in;
        par_lat <= par_en;
      end
      if (cap_par)        par_flag <= par_err;
      else if (eval_stop) par_flag <= 1'b0;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    load_cfg    = 1'b0;
    cap_par     = 1'b0;
    eval_stop   = 1'b0;
    dat_samp_en = 1'b1;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    case (state)
      IDLE: begin
        dat_samp_en = 1'b0;
        cnt_clr     = 1'b1;
        if (!rx_in) begin
          state_nx = START;
          load_cfg = 1'b1;
        end
      end
      START: begin
        cnt_en      = 1'b1;
        strt_chk_en = at_chk;
        if (at_last) begin
          if (strt_glitch) begin
            state_nx = IDLE;
            cnt_clr  = 1'b1;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        cnt_en   = 1'b1;
        deser_en = at_chk;
        if (at_last && bit_cnt == 4'(DATA_WIDTH))
          state_nx = par_lat ? PARITY : STOP;
      end
      PARITY: begin
        cnt_en     = 1'b1;
        par_chk_en = at_chk;
        if (at_last) begin
          cap_par  = 1'b1;
          state_nx = STOP;
        end
      end
      STOP: begin
        cnt_en     = 1'b1;
        stp_chk_en = at_chk;
        if (at_last) begin
          eval_stop = 1'b1;
          cnt_clr   = 1'b1;
          // a low line on the final stop edge is the next frame's start bit
          if (!rx_in) begin
            state_nx = START;
            load_cfg = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_clr  = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: expected pulses queued at stimulus time,
// a negedge monitor pops and compares each pulse the DUT emits.
module tb_uart_rx_fsm;
  localparam logic [5:0] K_STRT = 6'b100000;
  localparam logic [5:0] K_DES  = 6'b010000;
  localparam logic [5:0] K_PAR  = 6'b001000;
  localparam logic [5:0] K_STP  = 6'b000100;
  localparam logic [5:0] K_DV   = 6'b000010;
  localparam logic [5:0] K_FE   = 6'b000001;
  localparam int         NOLIM  = 32'h7fffffff;

  typedef struct {
    logic [5:0] kind;
    int         cyc;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       strt_glitch, par_err, stp_err;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, frame_err;

  logic       force_par = 1'b0, force_stp = 1'b0;
  logic [7:0] sr;
  int         cyc = 0;
  int         n_vec = 0, n_err = 0;
  exp_t       exp_q[$];
  exp_t       e;
  logic [5:0] act;

  uart_rx_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // registered checker and deserializer models
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      sr          <= 8'h00;
    end else begin
      if (strt_chk_en) strt_glitch <= rx_in;
      if (par_chk_en)  par_err     <= force_par;
      if (stp_chk_en)  stp_err     <= force_stp | ~rx_in;
      if (deser_en)    sr          <= {rx_in, sr[7:1]};
    end
  end

  always @(negedge clk) begin
    act = {strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, frame_err};
    if (act != 6'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: got kind=%b at cyc %0d, want none", act, cyc);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.kind || cyc != e.cyc || (act == K_DV && sr !== e.dat)) begin
          n_err++;
          $display("FAIL pulse: got kind=%b cyc=%0d byte=%h, want kind=%b cyc=%0d byte=%h",
                   act, cyc, sr, e.kind, e.cyc, e.dat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [5:0] k, input int c, input logic [7:0] d, input int lim);
    exp_t x;
    x.kind = k; x.cyc = c; x.dat = d;
    if (c < lim) exp_q.push_back(x);
  endtask

  // s = absolute cycle of the first START cycle, c = check edge, p = bit length
  task automatic expect_frame(input int s, input int p, input int c, input bit par,
                              input logic [7:0] d, input bit err, input int lim);
    int nbits;
    nbits = par ? 11 : 10;
    push(K_STRT, s + c, 8'h00, lim);
    for (int k = 0; k < 8; k++) push(K_DES, s + p*(k+1) + c, 8'h00, lim);
    if (par) push(K_PAR, s + 9*p + c, 8'h00, lim);
    push(K_STP, s + (nbits-1)*p + c, 8'h00, lim);
    push(err ? K_FE : K_DV, s + nbits*p, d, lim);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par, input int p, input int abort);
    logic [11:0] b;
    int n;
    b = '1;
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[k+1] = d[k];
    n = 10;
    if (par) begin b[9] = ^d; n = 11; end
    b[n-1] = 1'b1;
    for (int i = 0; i < n; i++) begin
      rx_in = b[i];
      for (int j = 0; j < p; j++) begin
        if (abort > 0 && (i*p + j) == abort) return;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    int s;
    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0;
    idle(3);
    check("reset_outputs", {dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
                            par_chk_en, stp_chk_en, data_valid, frame_err}, 32'h0);
    rst = 1'b1;
    idle(3);

    // P=8, no parity, 0xA5: deser at 14..70, stop check at 78, data_valid at 80
    s = cyc + 1;
    expect_frame(s, 8, 6, 1'b0, 8'hA5, 1'b0, NOLIM);
    send_frame(8'hA5, 1'b0, 8, 0);
    idle(6);

    // P=16 with parity, parity checker reports error: frame_err at 176
    prescale = 6'd16; par_en = 1'b1; force_par = 1'b1;
    s = cyc + 1;
    expect_frame(s, 16, 10, 1'b1, 8'h5A, 1'b1, NOLIM);
    send_frame(8'h5A, 1'b1, 16, 0);
    idle(6);
    force_par = 1'b0; par_en = 1'b0; prescale = 6'd8;

    // P=8, stop checker reports error: frame_err at 80
    force_stp = 1'b1;
    s = cyc + 1;
    expect_frame(s, 8, 6, 1'b0, 8'h0F, 1'b1, NOLIM);
    send_frame(8'h0F, 1'b0, 8, 0);
    idle(6);
    force_stp = 1'b0;

    // prescale below the minimum behaves as 8
    prescale = 6'd3;
    s = cyc + 1;
    expect_frame(s, 8, 6, 1'b0, 8'h81, 1'b0, NOLIM);
    send_frame(8'h81, 1'b0, 8, 0);
    idle(6);
    prescale = 6'd8;

    // 3-cycle glitch: start checker flags it, IDLE at cycle 8
    rx_in = 1'b0;
    s = cyc + 1;
    push(K_STRT, s + 6, 8'h00, NOLIM);
    idle(3);
    rx_in = 1'b1;
    idle(5);
    check("glitch_cyc7_samp_en", {31'h0, dat_samp_en}, 32'h1);
    check("glitch_cyc7_edge", {26'h0, edge_cnt}, 32'h7);
    idle(1);
    check("glitch_cyc8_idle", {31'h0, dat_samp_en}, 32'h0);
    check("glitch_cyc8_bit", {28'h0, bit_cnt}, 32'h0);
    idle(20);

    // back-to-back frames, second START the cycle after first LAST
    s = cyc + 1;
    expect_frame(s, 8, 6, 1'b0, 8'h3C, 1'b0, NOLIM);
    expect_frame(s + 80, 8, 6, 1'b0, 8'hC3, 1'b0, NOLIM);
    send_frame(8'h3C, 1'b0, 8, 0);
    send_frame(8'hC3, 1'b0, 8, 0);
    idle(6);

    // reset at cycle 40 of a frame aborts it
    s = cyc + 1;
    expect_frame(s, 8, 6, 1'b0, 8'h55, 1'b0, s + 40);
    send_frame(8'h55, 1'b0, 8, 41);
    check("abort_at_cycle40", cyc, s + 40);
    rst = 1'b0;
    #1;
    check("midframe_reset_outputs", {dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, deser_en,
                                     par_chk_en, stp_chk_en, data_valid, frame_err}, 32'h0);
    rx_in = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(30);
    check("after_reset_idle", {31'h0, dat_samp_en}, 32'h0);
    check("queue_drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
